pixel_dispatch: RTL and testbench

//  Schedules out-of-order pixel work across LANES render lanes feeding the pixel reorder (sort) buffer.

---
 rtl/pixel_dispatch.sv | 212 +++++++++++++++++++++
 tb/tb_pixel_dispatch.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : pixel_dispatch
// Description : Frame-level pixel work scheduler. Issues addresses
//               0..PIX_TOTAL-1 round-robin over ready render lanes. The
//               number of pixels in flight is capped at WINDOW so that
//               addresses never alias in the downstream reorder buffer.
//               Sequences each frame through RUN, DRAIN and DONE, and sends
//               a vs pulse to the sorter when the frame is complete.
// Ports       : clk, rst_n (async, active low)
//               frame_start  - 1-cycle pulse, begins a frame (IDLE only)
//               lane_ready   - per-lane "can accept one pixel"
//               retire       - sorter emitted one in-order pixel
//               disp_valid   - registered dispatch strobe
//               disp_lane    - one-hot target lane (0 when idle)
//               disp_addr    - dispatched pixel address
//               frame_vs     - 1-cycle pulse on frame completion
//               busy         - high in RUN or DRAIN
//               credit_err   - sticky, retire seen with nothing in flight
//               stall_cycles - (STALL_CNT_EN only) RUN cycles lost to the
//                              credit limit while some lane was eligible
// Options     : define STALL_CNT_EN to add the stall_cycles counter/port.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_dispatch #(
  parameter int LANES     = 4,
  parameter int WINDOW    = 16,
  parameter int PIX_TOTAL = 307200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [LANES-1:0] lane_ready,
  input  logic             retire,
  output logic             disp_valid,
  output logic [LANES-1:0] disp_lane,
  output logic [19:0]      disp_addr,
  output logic             frame_vs,
  output logic             busy,
  output logic             credit_err
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam int IW = $clog2(WINDOW) + 1;
  localparam int PW = $clog2(LANES);

  localparam logic [IW-1:0] C_WINDOW    = IW'(WINDOW);
  localparam logic [19:0]   C_LAST_ADDR = 20'(PIX_TOTAL - 1);
  localparam logic [PW-1:0] C_LAST_LANE = PW'(LANES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,      state_d;
  logic [19:0]      next_addr_q,  next_addr_d;
  logic [IW-1:0]    inflight_q,   inflight_d;
  logic [PW-1:0]    rr_q,         rr_d;
  logic             disp_valid_q, disp_valid_d;
  logic [LANES-1:0] disp_lane_q,  disp_lane_d;
  logic [19:0]      disp_addr_q,  disp_addr_d;
  logic             credit_err_q, credit_err_d;

  // --------------------------------------------------------------------------
  // Lane arbitration
  // --------------------------------------------------------------------------
  logic [LANES-1:0] w_elig;
  logic             w_any_elig;
  logic             w_credit_ok;
  logic             w_found;
  logic [PW-1:0]    w_grant_idx;
  logic [LANES-1:0] w_onehot;
  logic             w_fire;
  logic             w_ret_ok;

  // The lane dispatched last cycle is masked: it may still show ready for one
  // cycle before its own dispatch lands, and must not get a second pixel.
  assign w_elig      = (state_q == S_RUN) ? (lane_ready & ~disp_lane_q) : '0;
  assign w_any_elig  = |w_elig;
  assign w_credit_ok = (inflight_q < C_WINDOW);

  // First eligible lane at or after rr_q, wrapping around.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!w_found && w_elig[PW'((int'(rr_q) + k) % LANES)]) begin
        w_found     = 1'b1;
        w_grant_idx = PW'((int'(rr_q) + k) % LANES);
      end
    end
  end

  assign w_onehot = {{(LANES-1){1'b0}}, 1'b1} << w_grant_idx;
  // Credit check uses the registered count only, so a retire arriving while
  // the window is full frees the slot for the following cycle.
  assign w_fire   = w_found & w_credit_ok;
  // A retire with nothing in flight is dropped to avoid underflow.
  assign w_ret_ok = retire & (inflight_q != '0);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    next_addr_d  = next_addr_q;
    rr_d         = rr_q;
    inflight_d   = inflight_q;
    disp_valid_d = 1'b0;
    disp_lane_d  = '0;
    disp_addr_d  = disp_addr_q;
    credit_err_d = credit_err_q | (retire & (inflight_q == '0));

    if (w_fire) begin
      disp_valid_d = 1'b1;
      disp_lane_d  = w_onehot;
      disp_addr_d  = next_addr_q;
      rr_d         = (w_grant_idx == C_LAST_LANE) ? '0 : w_grant_idx + 1'b1;
      if (next_addr_q == C_LAST_ADDR) begin
        next_addr_d = '0;
        state_d     = S_DRAIN;
      end else begin
        next_addr_d = next_addr_q + 20'd1;
      end
    end

    case ({w_fire, w_ret_ok})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      S_IDLE:  if (frame_start) state_d = S_RUN;
      S_RUN:   ;  // exit to DRAIN handled with the last dispatch above
      S_DRAIN: if (inflight_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      next_addr_q  <= '0;
      inflight_q   <= '0;
      rr_q         <= '0;
      disp_valid_q <= 1'b0;
      disp_lane_q  <= '0;
      disp_addr_q  <= '0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_addr_q  <= next_addr_d;
      inflight_q   <= inflight_d;
      rr_q         <= rr_d;
      disp_valid_q <= disp_valid_d;
      disp_lane_q  <= disp_lane_d;
      disp_addr_q  <= disp_addr_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_lane  = disp_lane_q;
  assign disp_addr  = disp_addr_q;
  assign frame_vs   = (state_q == S_DONE);
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign credit_err = credit_err_q;

`ifdef STALL_CNT_EN
  // --------------------------------------------------------------------------
  // Stall counter: RUN cycles where a lane could take work but the window is
  // full. Saturates rather than wrapping.
  // --------------------------------------------------------------------------
  logic [31:0] stall_q, stall_d;
  logic        w_stall_inc;

  assign w_stall_inc = (state_q == S_RUN) & w_any_elig & ~w_credit_ok;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && frame_start) begin
      stall_d = '0;
    end else if (w_stall_inc && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  logic w_unused;
  assign w_unused = w_any_elig;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_dispatch
// Description : Self-checking bench for pixel_dispatch (LANES=4, WINDOW=16,
//               PIX_TOTAL=64) with a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_dispatch;

  localparam int LANES  = 4;
  localparam int WINDOW = 16;
  localparam int PIX    = 64;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [3:0]  lane_ready;
  logic        retire;
  logic        disp_valid;
  logic [3:0]  disp_lane;
  logic [19:0] disp_addr;
  logic        frame_vs;
  logic        busy;
  logic        credit_err;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  pixel_dispatch #(
    .LANES     (LANES),
    .WINDOW    (WINDOW),
    .PIX_TOTAL (PIX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .lane_ready  (lane_ready),
    .retire      (retire),
    .disp_valid  (disp_valid),
    .disp_lane   (disp_lane),
    .disp_addr   (disp_addr),
    .frame_vs    (frame_vs),
    .busy        (busy),
    .credit_err  (credit_err)
`ifdef STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done.
  int          m_phase;
  int          m_addr;
  int          m_inflight;
  int          m_rr;
  logic        m_valid;
  logic [3:0]  m_lane;
  logic [19:0] m_daddr;
  logic        m_vs;
  logic        m_busy;
  logic        m_cerr;
  logic [31:0] m_stall;

  task automatic model_reset();
    m_phase = 0; m_addr = 0; m_inflight = 0; m_rr = 0;
    m_valid = 1'b0; m_lane = 4'b0; m_daddr = 20'd0;
    m_vs = 1'b0; m_busy = 1'b0; m_cerr = 1'b0; m_stall = 32'd0;
  endtask

  // One clock of the frame rules, using the inputs present at the edge.
  task automatic model_step();
    int         old_phase;
    int         old_inf;
    int         g;
    logic [3:0] ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    old_phase = m_phase;
    old_inf   = m_inflight;
    ok = (old_phase == 1) ? (lane_ready & ~m_lane) : 4'b0;
    g  = -1;
    if (old_inf < WINDOW) begin
      for (int k = 0; k < LANES; k++) begin
        if (g < 0 && ok[2'((m_rr + k) % LANES)]) g = (m_rr + k) % LANES;
      end
    end
    if (retire) begin
      if (old_inf == 0) m_cerr = 1'b1;
      else m_inflight = m_inflight - 1;
    end
    if (g >= 0) m_inflight = m_inflight + 1;
    if (old_phase == 1 && ok != 4'b0 && old_inf == WINDOW && m_stall != 32'hFFFF_FFFF)
      m_stall = m_stall + 1;
    if (g >= 0) begin
      m_valid = 1'b1;
      m_lane  = 4'b0001 << g;
      m_daddr = 20'(m_addr);
      m_rr    = (g + 1) % LANES;
      if (m_addr == PIX - 1) begin
        m_addr  = 0;
        m_phase = 2;
      end else begin
        m_addr = m_addr + 1;
      end
    end else begin
      m_valid = 1'b0;
      m_lane  = 4'b0;
    end
    case (old_phase)
      0: if (frame_start) begin m_phase = 1; m_stall = 32'd0; end
      2: if (old_inf == 0) m_phase = 3;
      3: m_phase = 0;
      default: ;
    endcase
    m_vs   = (m_phase == 3);
    m_busy = (m_phase == 1) || (m_phase == 2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Completes an open frame: retires everything outstanding, returns to IDLE.
  task automatic finish_frame();
    lane_ready = 4'hF;
    frame_start = 1'b0;
    for (int c = 0; c < 500 && m_phase != 0; c++) begin
      retire = (m_inflight > 0);
      tick();
    end
    retire = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; lane_ready = 4'hF; frame_start = 1'b1; retire = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if ({disp_valid, disp_lane, disp_addr, frame_vs, busy, credit_err} !== 27'd0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got v=%0b lane=%b addr=%0d vs=%0b busy=%0b cerr=%0b, want all 0",
                 c, disp_valid, disp_lane, disp_addr, frame_vs, busy, credit_err);
      end
    end
`ifdef STALL_CNT_EN
    total++;
    if (stall_cycles !== 32'd0) begin
      bad++; $display("FAIL reset_stall got %0d want 0", stall_cycles);
    end
`endif
    frame_start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || disp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release got busy=%0b v=%0b want 0 0", busy, disp_valid);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_full_frame();
    int n_disp = 0, n_vs = 0, last_ret = -1, vs_cyc = -1;
    lane_ready = 4'hF; retire = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      retire = disp_valid;
      tick();
      if (retire) last_ret = c;
      total++;
      if (disp_valid !== m_valid || disp_lane !== m_lane || (m_valid && disp_addr !== m_daddr)) begin
        bad++;
        $display("FAIL full_frame_model cyc=%0d got v=%0b lane=%b addr=%0d want v=%0b lane=%b addr=%0d",
                 c, disp_valid, disp_lane, disp_addr, m_valid, m_lane, m_daddr);
      end
      if (disp_valid === 1'b1) begin
        total++;
        if (disp_addr !== 20'(n_disp) || disp_lane !== (4'b0001 << (n_disp % 4))) begin
          bad++;
          $display("FAIL full_frame_order n=%0d got lane=%b addr=%0d want lane=%b addr=%0d",
                   n_disp, disp_lane, disp_addr, 4'b0001 << (n_disp % 4), n_disp);
        end
        n_disp++;
      end
      if (frame_vs === 1'b1) begin n_vs++; vs_cyc = c; end
      else if (n_vs > 0) break;
    end
    retire = 1'b0;
    total++;
    if (n_disp != PIX) begin bad++; $display("FAIL full_frame_count got %0d want %0d", n_disp, PIX); end
    total++;
    if (n_vs != 1) begin bad++; $display("FAIL full_frame_vs_pulses got %0d want 1", n_vs); end
    total++;
    if (!(vs_cyc > last_ret)) begin
      bad++; $display("FAIL full_frame_vs_after_retire got vs_cyc=%0d want > %0d", vs_cyc, last_ret);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL full_frame_busy_end got %0b want 0", busy); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_window();
    int n_disp = 0;
    int last_addr = -1;
    lane_ready = 4'hF; retire = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      total++;
      if (disp_valid !== m_valid || disp_lane !== m_lane || (m_valid && disp_addr !== m_daddr)) begin
        bad++;
        $display("FAIL window_model cyc=%0d got v=%0b lane=%b addr=%0d want v=%0b lane=%b addr=%0d",
                 c, disp_valid, disp_lane, disp_addr, m_valid, m_lane, m_daddr);
      end
      if (disp_valid === 1'b1) begin n_disp++; last_addr = int'(disp_addr); end
    end
    total++;
    if (n_disp != WINDOW || last_addr != WINDOW - 1) begin
      bad++; $display("FAIL window_limit got n=%0d last=%0d want n=%0d last=%0d",
                      n_disp, last_addr, WINDOW, WINDOW - 1);
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL window_busy got %0b want 1", busy); end
`ifdef STALL_CNT_EN
    total++;
    if (stall_cycles !== 32'd24 || stall_cycles !== m_stall) begin
      bad++; $display("FAIL window_stall got %0d want 24 (model %0d)", stall_cycles, m_stall);
    end
`endif
    retire = 1'b1; tick(); retire = 1'b0;
    total++;
    if (disp_valid !== 1'b0) begin bad++; $display("FAIL window_same_cycle got v=%0b want 0", disp_valid); end
    tick();
    total++;
    if (disp_valid !== 1'b1 || disp_addr !== 20'd16) begin
      bad++; $display("FAIL window_resume got v=%0b addr=%0d want v=1 addr=16", disp_valid, disp_addr);
    end
    finish_frame();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL window_drain_busy got %0b want 0", busy); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single_lane();
    int   n_disp = 0;
    int   n_vs = 0;
    logic prev_v = 1'b0;
    lane_ready = 4'b0100; retire = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      retire = disp_valid;
      tick();
      total++;
      if (disp_valid !== m_valid || disp_lane !== m_lane || (m_valid && disp_addr !== m_daddr)) begin
        bad++;
        $display("FAIL single_lane_model cyc=%0d got v=%0b lane=%b addr=%0d want v=%0b lane=%b addr=%0d",
                 c, disp_valid, disp_lane, disp_addr, m_valid, m_lane, m_daddr);
      end
      if (disp_valid === 1'b1) begin
        total++;
        if (disp_lane !== 4'b0100 || prev_v) begin
          bad++; $display("FAIL single_lane_mask cyc=%0d got lane=%b prev_v=%0b want lane=0100 prev_v=0",
                          c, disp_lane, prev_v);
        end
        n_disp++;
      end
      prev_v = disp_valid;
      if (frame_vs === 1'b1) n_vs++;
      else if (n_vs > 0) break;
    end
    retire = 1'b0;
    total++;
    if (n_disp != PIX || n_vs != 1) begin
      bad++; $display("FAIL single_lane_count got n=%0d vs=%0d want n=%0d vs=1", n_disp, n_vs, PIX);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_idle_retire();
    int n_disp = 0;
    lane_ready = 4'hF; frame_start = 1'b0;
    retire = 1'b1; tick(); retire = 1'b0;
    total++;
    if (credit_err !== 1'b1) begin bad++; $display("FAIL idle_retire_err got %0b want 1", credit_err); end
    for (int c = 0; c < 3; c++) tick();
    total++;
    if (credit_err !== 1'b1 || busy !== 1'b0 || disp_valid !== 1'b0) begin
      bad++; $display("FAIL idle_retire_sticky got cerr=%0b busy=%0b v=%0b want 1 0 0",
                      credit_err, busy, disp_valid);
    end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int c = 0; c < 300 && m_phase != 0; c++) begin
      retire = disp_valid;
      tick();
      total++;
      if (disp_valid !== m_valid || disp_lane !== m_lane || (m_valid && disp_addr !== m_daddr)
          || frame_vs !== m_vs) begin
        bad++;
        $display("FAIL idle_retire_frame cyc=%0d got v=%0b lane=%b addr=%0d vs=%0b want v=%0b lane=%b addr=%0d vs=%0b",
                 c, disp_valid, disp_lane, disp_addr, frame_vs, m_valid, m_lane, m_daddr, m_vs);
      end
      if (disp_valid === 1'b1) n_disp++;
    end
    retire = 1'b0;
    total++;
    if (n_disp != PIX || credit_err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_retire_next_frame got n=%0d cerr=%0b busy=%0b want n=%0d cerr=1 busy=0",
                      n_disp, credit_err, busy, PIX);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_midframe();
    bit hit = 1'b0;
    bit got = 1'b0;
    lane_ready = 4'hF; retire = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      retire = disp_valid;
      tick();
      if (disp_valid === 1'b1 && disp_addr === 20'd30) hit = 1'b1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL midframe_reach_addr30 got no dispatch of 30 want one"); end
    retire = 1'b0;
    rst_n = 1'b0;
    tick();
    total++;
    if ({disp_valid, disp_lane, disp_addr, frame_vs, busy, credit_err} !== 27'd0) begin
      bad++;
      $display("FAIL midframe_reset got v=%0b lane=%b addr=%0d vs=%0b busy=%0b cerr=%0b want all 0",
               disp_valid, disp_lane, disp_addr, frame_vs, busy, credit_err);
    end
    rst_n = 1'b1;
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      tick();
      if (disp_valid === 1'b1) got = 1'b1;
    end
    total++;
    if (!got || disp_addr !== 20'd0 || disp_lane !== 4'b0001) begin
      bad++; $display("FAIL midframe_restart got v=%0b addr=%0d lane=%b want v=1 addr=0 lane=0001",
                      got, disp_addr, disp_lane);
    end
    finish_frame();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    int n_vs = 0;
    frame_start = 1'b1; lane_ready = 4'($urandom); retire = 1'b0;
    tick();
    frame_start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      lane_ready  = 4'($urandom);
      retire      = (c < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 15) == 0);
      tick();
      total++;
      if (disp_valid !== m_valid || disp_lane !== m_lane || (m_valid && disp_addr !== m_daddr)
          || frame_vs !== m_vs || busy !== m_busy || credit_err !== m_cerr) begin
        bad++;
        $display("FAIL random_model cyc=%0d got v=%0b lane=%b addr=%0d vs=%0b busy=%0b cerr=%0b want v=%0b lane=%b addr=%0d vs=%0b busy=%0b cerr=%0b",
                 c, disp_valid, disp_lane, disp_addr, frame_vs, busy, credit_err,
                 m_valid, m_lane, m_daddr, m_vs, m_busy, m_cerr);
      end
`ifdef STALL_CNT_EN
      total++;
      if (stall_cycles !== m_stall) begin
        bad++; $display("FAIL random_stall cyc=%0d got %0d want %0d", c, stall_cycles, m_stall);
      end
`endif
      if (m_vs) n_vs++;
      if (n_vs > 0 && m_phase == 0) break;
    end
    frame_start = 1'b0; retire = 1'b0;
    total++;
    if (n_vs != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL random_complete got vs=%0d busy=%0b want vs=1 busy=0", n_vs, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; lane_ready = 4'h0; retire = 1'b0;
    model_reset();
    test_reset();
    test_full_frame();
    test_window();
    test_single_lane();
    test_idle_retire();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
